// File: rtl/alarm_ctrl_pkg.sv
// Shared types and limits for the alarm controller.
// Optional macro HOURLY_CHIME_EN is consumed in alarm_ctrl.sv.
package alarm_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam int               BCD_W    = 8;
    localparam logic [BCD_W-1:0] HOUR_MAX = 8'h23;
    localparam logic [BCD_W-1:0] MIN_MAX  = 8'h59;

    // Width of a counter that must hold values 0..n (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/alarm_ctrl_if.sv
// Time, key and buzzer-side signals of the alarm controller.
interface alarm_ctrl_if;
    logic       clk1hz;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic       alarm_on;
    logic       set_mode;
    logic       key_hour_inc;
    logic       key_min_inc;
    logic       key_stop;
    logic       key_snooze;
    logic       beepen;
    logic       ringing;
    logic [7:0] alarm_hour;
    logic [7:0] alarm_min;

    modport master (
        output clk1hz, cur_hour, cur_min, cur_sec, alarm_on, set_mode,
               key_hour_inc, key_min_inc, key_stop, key_snooze,
        input  beepen, ringing, alarm_hour, alarm_min
    );
    modport slave (
        input  clk1hz, cur_hour, cur_min, cur_sec, alarm_on, set_mode,
               key_hour_inc, key_min_inc, key_stop, key_snooze,
        output beepen, ringing, alarm_hour, alarm_min
    );
endinterface

// File: rtl/alarm_ctrl_bcd_wrap_inc.sv
// Combinational two-digit BCD increment that wraps to 00 past i_max.
import alarm_pkg::*;

module bcd_wrap_inc (
    input  logic [BCD_W-1:0] i_val,
    input  logic [BCD_W-1:0] i_max,
    output logic [BCD_W-1:0] o_next
);
    logic [3:0] w_hi;
    logic [3:0] w_lo;

    assign w_hi = i_val[7:4];
    assign w_lo = i_val[3:0];

    // Any malformed digit also collapses to 00 so the output is always legal BCD.
    always_comb begin
        o_next = '0;
        if (w_hi > 4'd9 || w_lo > 4'd9 || i_val >= i_max)
            o_next = '0;
        else if (w_lo == 4'd9)
            o_next = {w_hi + 4'd1, 4'd0};
        else
            o_next = {w_hi, w_lo + 4'd1};
    end
endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD alarm edit, match trigger, ring/snooze FSM driving beepen.
// Define HOURLY_CHIME_EN to add a single beepen pulse on each hour while idle.
import alarm_pkg::*;

module alarm_ctrl #(
    parameter int         RING_REPEATS       = 4,
    parameter int         BURST_PERIOD_S     = 8,
    parameter int         SNOOZE_S           = 300,
    parameter logic [7:0] DEFAULT_ALARM_HOUR = 8'h07,
    parameter logic [7:0] DEFAULT_ALARM_MIN  = 8'h00
) (
    input  logic          clk50mhz,
    input  logic          rst_n,
    alarm_ctrl_if.slave   bus
);
    localparam int SEC_W   = cnt_w(BURST_PERIOD_S - 1);
    localparam int BURST_W = cnt_w(RING_REPEATS);
    localparam int SNZ_W   = cnt_w(SNOOZE_S);
    localparam logic [SEC_W-1:0]   L_SEC_LAST = SEC_W'(BURST_PERIOD_S - 1);
    localparam logic [BURST_W-1:0] L_REPEATS  = BURST_W'(RING_REPEATS);
    localparam logic [SNZ_W-1:0]   L_SNOOZE   = SNZ_W'(SNOOZE_S);

    // Bit order: {clk1hz, hour_inc, min_inc, stop, snooze}
    logic [4:0] w_raw, w_rise;
    logic [4:0] r_s1, r_s2, r_s3;
    logic       w_tick, w_hour_rise, w_min_rise, w_stop_rise, w_snooze_rise;

    assign w_raw  = {bus.clk1hz, bus.key_hour_inc, bus.key_min_inc, bus.key_stop, bus.key_snooze};
    assign w_rise = r_s2 & ~r_s3;
    assign {w_tick, w_hour_rise, w_min_rise, w_stop_rise, w_snooze_rise} = w_rise;

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    logic [BCD_W-1:0] r_alarm_hour, r_alarm_min, w_hour_next, w_min_next;

    bcd_wrap_inc u_hour_inc (.i_val(r_alarm_hour), .i_max(HOUR_MAX), .o_next(w_hour_next));
    bcd_wrap_inc u_min_inc  (.i_val(r_alarm_min),  .i_max(MIN_MAX),  .o_next(w_min_next));

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm_hour <= DEFAULT_ALARM_HOUR;
            r_alarm_min  <= DEFAULT_ALARM_MIN;
        end else if (bus.set_mode) begin
            if (w_hour_rise) r_alarm_hour <= w_hour_next;
            if (w_min_rise)  r_alarm_min  <= w_min_next;
        end
    end

    // The first cycle after reset loads both edge stages with the same sample,
    // so a condition already true at release is not seen as a rising edge.
    logic w_match, r_match, r_match_d, r_primed, w_match_rise;
    assign w_match = bus.alarm_on && bus.cur_hour == r_alarm_hour &&
                     bus.cur_min == r_alarm_min && bus.cur_sec == 8'h00;
    assign w_match_rise = r_match & ~r_match_d;

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_primed  <= 1'b0;
            r_match   <= 1'b0;
            r_match_d <= 1'b0;
        end else begin
            r_primed  <= 1'b1;
            r_match   <= w_match;
            r_match_d <= r_primed ? r_match : w_match;
        end
    end

`ifdef HOURLY_CHIME_EN
    logic w_chime, r_chime, r_chime_d, w_chime_rise;
    assign w_chime      = bus.cur_min == 8'h00 && bus.cur_sec == 8'h00;
    assign w_chime_rise = r_chime & ~r_chime_d;

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_chime   <= 1'b0;
            r_chime_d <= 1'b0;
        end else begin
            r_chime   <= w_chime;
            r_chime_d <= r_primed ? r_chime : w_chime;
        end
    end
`endif

    state_t             r_state;
    logic               r_beepen;
    logic [SEC_W-1:0]   r_sec_cnt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [SNZ_W-1:0]   r_snooze_cnt;

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_beepen     <= 1'b0;
            r_sec_cnt    <= '0;
            r_burst_cnt  <= '0;
            r_snooze_cnt <= '0;
        end else begin
            r_beepen <= 1'b0;
            if (!bus.alarm_on) begin
                r_state      <= IDLE;
                r_sec_cnt    <= '0;
                r_burst_cnt  <= '0;
                r_snooze_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_match_rise) begin
                            r_state     <= RINGING;
                            r_beepen    <= 1'b1;
                            r_burst_cnt <= BURST_W'(1);
                            r_sec_cnt   <= '0;
                        end
`ifdef HOURLY_CHIME_EN
                        else if (w_chime_rise) begin
                            r_beepen <= 1'b1;
                        end
`endif
                    end
                    RINGING: begin
                        if (w_stop_rise) begin
                            r_state <= IDLE;
                        end else if (w_snooze_rise) begin
                            r_state      <= SNOOZE;
                            r_snooze_cnt <= L_SNOOZE;
                        end else if (w_tick) begin
                            if (r_sec_cnt == L_SEC_LAST) begin
                                r_sec_cnt <= '0;
                                if (r_burst_cnt < L_REPEATS) begin
                                    r_beepen    <= 1'b1;
                                    r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                                end else begin
                                    r_state <= IDLE;
                                end
                            end else begin
                                r_sec_cnt <= r_sec_cnt + SEC_W'(1);
                            end
                        end
                    end
                    SNOOZE: begin
                        if (w_stop_rise) begin
                            r_state <= IDLE;
                        end else if (w_tick) begin
                            r_snooze_cnt <= r_snooze_cnt - SNZ_W'(1);
                            if (r_snooze_cnt == SNZ_W'(1)) begin
                                r_state     <= RINGING;
                                r_beepen    <= 1'b1;
                                r_burst_cnt <= BURST_W'(1);
                                r_sec_cnt   <= '0;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.beepen     = r_beepen;
    assign bus.ringing    = (r_state != IDLE);
    assign bus.alarm_hour = r_alarm_hour;
    assign bus.alarm_min  = r_alarm_min;
endmodule
